keypad_counter_ctrl: RTL and testbench
======================================

Name: keypad_counter_ctrl

Overview:
Parametrised successor to the 3-bit keypad-cleared up-counter FSM.
- Counts up from 0 to a programmable LIMIT when enabled, then either saturates or wraps.
- Raises a Moore match flag at a programmable count.
- Accepts synchronised, edge-detected keypad presses:
  - key 0 clears the count.
  - keys 1..KEYS-1 load the count directly.
- Sits between the keypad input-control layer and downstream sequence and display logic.

Parameters:
- WIDTH, 3: count register width.
- LIMIT, 7: terminal count; 1 <= LIMIT <= 2^WIDTH-1.
- MATCH, 4: count value that asserts match; MATCH <= LIMIT.
- WRAP, 0: 0 = saturate at LIMIT; 1 = roll over LIMIT -> 0.
- KEYS, 10: keypad line count; KEYS >= 2.

Ports:
- clk, input, 1: rising-edge clock.
- clear, input, 1: asynchronous, active-high reset of all state.
- enable, input, 1: count advance enable; sampled each rising edge.
- keypad, input, KEYS: raw key lines, asynchronous to clk; bit k = key k pressed.
- count, output, WIDTH: current count, registered.
- match, output, 1: count == MATCH, decoded from the count register.
- at_limit, output, 1: count == LIMIT, decoded from the count register.
- wrapped, output, 1: one-cycle registered pulse on a LIMIT -> 0 rollover.
- key_event, output, 1: one-cycle registered pulse when a press is accepted.
- key_code, output, $clog2(KEYS): index of the last accepted key, registered.

Behaviour:
- Reset: clear high forces, immediately and without waiting for clk:
  - count = 0, wrapped = 0, key_event = 0, key_code = 0.
  - Both synchroniser stages = 0; previous-sample register = 0.
  - match = (MATCH == 0); at_limit = 0.
  - Deasserting clear mid-operation resumes from these values on the next edge. No partial key is retained.
- Keypad path:
  - Two-flop synchroniser s1 -> s2, then a previous-sample register p.
  - A press is accepted at an edge where s2 is one-hot and p == 0. This is the 3rd rising edge after keypad settles.
  - A held key never repeats.
  - A multi-key value or a bounce between non-zero codes is ignored: no key_event, no count change.
  - The next press is accepted only after s2 returns to all-zero.
- Key action at the acceptance edge:
  - key_code <= k.
  - key_event = 1 for exactly the following cycle.
  - k == 0: count <= 0.
  - 1 <= k <= LIMIT: count <= k.
  - k > LIMIT: count unchanged; key_event still pulses.
- Count advance (no key accepted this edge, enable = 1):
  - count < LIMIT: count <= count + 1.
  - count == LIMIT, WRAP = 0: count holds.
  - count == LIMIT, WRAP = 1: count <= 0 and wrapped = 1 for one cycle.
  - enable = 0: count holds.
- Priority: clear > accepted key action > enable advance. A key action on the same edge as a LIMIT rollover suppresses the wrapped pulse.
- Arithmetic: increment is WIDTH bits, unsigned. No out-of-range value is ever stored; a load value is truncated to WIDTH only when k <= LIMIT.
- match and at_limit are pure decodes of count, with zero latency relative to count.

Test Plan:
- Defaults, clear pulse then enable = 1 for 10 cycles -> count 0,1,...,7,7,7; match high only while count = 4; at_limit high from count = 7; wrapped never asserts.
- WRAP = 1, enable = 1 from reset for 9 cycles -> count 0..7 then 0; wrapped high exactly one cycle after the 7 -> 0 edge.
- enable = 0, keypad = 10'b00_0010_0000 (key 5) held 20 cycles -> count = 5 from the 3rd edge after the press; key_event one single cycle; key_code = 5; no repeat while held.
- count = 6, key 0 pressed on the edge where the count would otherwise advance -> count = 0, not 7; key_event pulse; key_code = 0.
- keypad = 10'b00_0000_0110 (keys 1 and 2 together), then release -> no key_event; count unchanged or advancing normally per enable.
- count mid-run at 3, clear asserted between clock edges -> count = 0 and key_event = 0 immediately. Counting resumes from 0 on the first edge after deassertion.
- LIMIT = 5, key 8 pressed -> key_event pulses, key_code = 8, count unchanged.

Source files
------------

// File: rtl/keypad_counter_ctrl.sv
// Up-counter with saturate/wrap at LIMIT, a match decode, and a synchronised,
// edge-detected keypad that clears or loads the count.
module keypad_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 7,
    parameter int MATCH = 4,
    parameter int WRAP  = 0,
    parameter int KEYS  = 10
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [KEYS-1:0]         keypad,
    output logic [WIDTH-1:0]        count,
    output logic                    match,
    output logic                    at_limit,
    output logic                    wrapped,
    output logic                    key_event,
    output logic [$clog2(KEYS)-1:0] key_code
);

    localparam int KW = $clog2(KEYS);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] MATCH_V = WIDTH'(MATCH);

    logic [KEYS-1:0]  r_s1;
    logic [KEYS-1:0]  r_s2;
    logic [KEYS-1:0]  r_p;
    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic             r_key_event;
    logic [KW-1:0]    r_key_code;

    logic             w_onehot;
    logic             w_accept;
    logic [KW-1:0]    w_key_idx;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrapped_nxt;
    logic             w_key_event_nxt;
    logic [KW-1:0]    w_key_code_nxt;

    // A press counts only on the first one-hot sample after an all-zero one,
    // so held keys, chords and bounces between codes are all rejected.
    assign w_onehot = (r_s2 != '0) && ((r_s2 & (r_s2 - KEYS'(1))) == '0);
    assign w_accept = w_onehot && (r_p == '0);

    always_comb begin
        w_key_idx = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (r_s2[k]) begin
                w_key_idx = KW'(k);
            end
        end
    end

    always_comb begin
        w_count_nxt     = r_count;
        w_wrapped_nxt   = 1'b0;
        w_key_event_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;
        if (w_accept) begin
            w_key_event_nxt = 1'b1;
            w_key_code_nxt  = w_key_idx;
            // Keys above LIMIT are reported but never stored in the count.
            if (int'(w_key_idx) <= LIMIT) begin
                w_count_nxt = WIDTH'(w_key_idx);
            end
        end else if (enable) begin
            if (r_count < LIMIT_V) begin
                w_count_nxt = r_count + WIDTH'(1);
            end else if (WRAP != 0) begin
                w_count_nxt   = '0;
                w_wrapped_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_p         <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_key_event <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_s1        <= keypad;
            r_s2        <= r_s1;
            r_p         <= r_s2;
            r_count     <= w_count_nxt;
            r_wrapped   <= w_wrapped_nxt;
            r_key_event <= w_key_event_nxt;
            r_key_code  <= w_key_code_nxt;
        end
    end

    assign count     = r_count;
    assign match     = (r_count == MATCH_V);
    assign at_limit  = (r_count == LIMIT_V);
    assign wrapped   = r_wrapped;
    assign key_event = r_key_event;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_counter_ctrl.sv
// Bench for keypad_counter_ctrl: default, wrapping and LIMIT=5 instances share
// clock and stimulus; expectations are queued per scenario and popped per cycle.
module tb_keypad_counter_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] keypad = '0;

    logic [2:0] a_count, w_count, l_count;
    logic       a_match, w_match, l_match;
    logic       a_at_limit, w_at_limit, l_at_limit;
    logic       a_wrapped, w_wrapped, l_wrapped;
    logic       a_key_event, w_key_event, l_key_event;
    logic [3:0] a_key_code, w_key_code, l_key_code;

    keypad_counter_ctrl dut_a (
        .clk(clk), .clear(clear), .enable(enable), .keypad(keypad),
        .count(a_count), .match(a_match), .at_limit(a_at_limit),
        .wrapped(a_wrapped), .key_event(a_key_event), .key_code(a_key_code)
    );

    keypad_counter_ctrl #(.WRAP(1)) dut_w (
        .clk(clk), .clear(clear), .enable(enable), .keypad(keypad),
        .count(w_count), .match(w_match), .at_limit(w_at_limit),
        .wrapped(w_wrapped), .key_event(w_key_event), .key_code(w_key_code)
    );

    keypad_counter_ctrl #(.LIMIT(5), .MATCH(2)) dut_l (
        .clk(clk), .clear(clear), .enable(enable), .keypad(keypad),
        .count(l_count), .match(l_match), .at_limit(l_at_limit),
        .wrapped(l_wrapped), .key_event(l_key_event), .key_code(l_key_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [2:0] exp_cnt_q[$];
    logic       exp_ke_q[$];
    logic [3:0] exp_kc_q[$];
    logic       exp_w_q[$];
    logic [2:0] e_cnt;
    logic       e_ke;
    logic [3:0] e_kc;
    logic       e_w;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic test_reset;
        #1 clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", a_count); end
            n_checks++; if (a_match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %0b want 0", a_match); end
            n_checks++; if (a_at_limit !== 1'b0) begin n_fail++; $display("FAIL reset_at_limit got %0b want 0", a_at_limit); end
            n_checks++; if (a_wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped got %0b want 0", a_wrapped); end
            n_checks++; if (a_key_event !== 1'b0) begin n_fail++; $display("FAIL reset_key_event got %0b want 0", a_key_event); end
            n_checks++; if (a_key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code got %0d want 0", a_key_code); end
            n_checks++; if (l_match !== 1'b0) begin n_fail++; $display("FAIL reset_l_match got %0b want 0", l_match); end
            // Second pass: clock edges with enable and a key present must not move anything.
            enable = 1'b1;
            keypad = 10'd2;
            tick();
        end
        keypad = '0;
        enable = 1'b0;
        clear = 1'b0;
        tick();
    endtask

    task automatic test_saturate;
        do_clear();
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) exp_cnt_q.push_back((i > 7) ? 3'd7 : 3'(i));
        while (exp_cnt_q.size() > 0) begin
            tick();
            e_cnt = exp_cnt_q.pop_front();
            n_checks++; if (a_count !== e_cnt) begin n_fail++; $display("FAIL sat_count got %0d want %0d", a_count, e_cnt); end
            n_checks++; if (a_match !== (e_cnt == 3'd4)) begin n_fail++; $display("FAIL sat_match got %0b at count %0d", a_match, e_cnt); end
            n_checks++; if (a_at_limit !== (e_cnt == 3'd7)) begin n_fail++; $display("FAIL sat_at_limit got %0b at count %0d", a_at_limit, e_cnt); end
            n_checks++; if (a_wrapped !== 1'b0) begin n_fail++; $display("FAIL sat_wrapped got %0b want 0", a_wrapped); end
        end
        enable = 1'b0;
    endtask

    task automatic test_wrap;
        do_clear();
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            exp_cnt_q.push_back(3'(i % 8));
            exp_w_q.push_back(i == 8);
        end
        while (exp_cnt_q.size() > 0) begin
            tick();
            e_cnt = exp_cnt_q.pop_front();
            e_w = exp_w_q.pop_front();
            n_checks++; if (w_count !== e_cnt) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", w_count, e_cnt); end
            n_checks++; if (w_wrapped !== e_w) begin n_fail++; $display("FAIL wrap_pulse got %0b want %0b", w_wrapped, e_w); end
            n_checks++; if (w_at_limit !== (e_cnt == 3'd7)) begin n_fail++; $display("FAIL wrap_at_limit got %0b at count %0d", w_at_limit, e_cnt); end
        end
        enable = 1'b0;
    endtask

    task automatic test_key_load;
        do_clear();
        enable = 1'b0;
        keypad = 10'b00_0010_0000;
        for (int i = 1; i <= 20; i++) begin
            exp_cnt_q.push_back((i >= 3) ? 3'd5 : 3'd0);
            exp_ke_q.push_back(i == 3);
            exp_kc_q.push_back((i >= 3) ? 4'd5 : 4'd0);
        end
        while (exp_cnt_q.size() > 0) begin
            tick();
            e_cnt = exp_cnt_q.pop_front(); e_ke = exp_ke_q.pop_front(); e_kc = exp_kc_q.pop_front();
            n_checks++; if (a_count !== e_cnt) begin n_fail++; $display("FAIL load_count got %0d want %0d", a_count, e_cnt); end
            n_checks++; if (a_key_event !== e_ke) begin n_fail++; $display("FAIL load_key_event got %0b want %0b", a_key_event, e_ke); end
            n_checks++; if (a_key_code !== e_kc) begin n_fail++; $display("FAIL load_key_code got %0d want %0d", a_key_code, e_kc); end
        end
        keypad = '0;
        repeat (3) tick();
    endtask

    task automatic test_key_priority;
        do_clear();
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_cnt_q.push_back((i <= 6) ? 3'(i) : 3'(i - 7));
            exp_ke_q.push_back(i == 7);
        end
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) keypad = 10'd1;
            tick();
            e_cnt = exp_cnt_q.pop_front(); e_ke = exp_ke_q.pop_front();
            n_checks++; if (a_count !== e_cnt) begin n_fail++; $display("FAIL prio_count got %0d want %0d", a_count, e_cnt); end
            n_checks++; if (a_key_event !== e_ke) begin n_fail++; $display("FAIL prio_key_event got %0b want %0b", a_key_event, e_ke); end
            n_checks++; if (a_key_code !== 4'd0) begin n_fail++; $display("FAIL prio_key_code got %0d want 0", a_key_code); end
        end
        keypad = '0;
        enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_multi_key;
        do_clear();
        enable = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            exp_cnt_q.push_back((i >= 15) ? 3'd2 : 3'd0);
            exp_ke_q.push_back(i == 15);
            exp_kc_q.push_back((i >= 15) ? 4'd2 : 4'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            if (i == 1)  keypad = 10'b00_0000_0110;
            if (i == 5)  keypad = 10'b00_0000_0100;
            if (i == 9)  keypad = '0;
            if (i == 13) keypad = 10'b00_0000_0100;
            tick();
            e_cnt = exp_cnt_q.pop_front(); e_ke = exp_ke_q.pop_front(); e_kc = exp_kc_q.pop_front();
            n_checks++; if (a_count !== e_cnt) begin n_fail++; $display("FAIL multi_count cyc %0d got %0d want %0d", i, a_count, e_cnt); end
            n_checks++; if (a_key_event !== e_ke) begin n_fail++; $display("FAIL multi_key_event cyc %0d got %0b want %0b", i, a_key_event, e_ke); end
            n_checks++; if (a_key_code !== e_kc) begin n_fail++; $display("FAIL multi_key_code cyc %0d got %0d want %0d", i, a_key_code, e_kc); end
        end
        keypad = '0;
        repeat (3) tick();
    endtask

    task automatic test_clear_async;
        do_clear();
        enable = 1'b1;
        keypad = 10'b00_0000_1000;
        exp_cnt_q.push_back(3'd3); exp_ke_q.push_back(1'b1); exp_kc_q.push_back(4'd3);
        exp_cnt_q.push_back(3'd0); exp_ke_q.push_back(1'b0); exp_kc_q.push_back(4'd0);
        exp_cnt_q.push_back(3'd1); exp_ke_q.push_back(1'b0); exp_kc_q.push_back(4'd0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            e_cnt = exp_cnt_q.pop_front(); e_ke = exp_ke_q.pop_front(); e_kc = exp_kc_q.pop_front();
            n_checks++; if (a_count !== e_cnt) begin n_fail++; $display("FAIL async_count step %0d got %0d want %0d", i, a_count, e_cnt); end
            n_checks++; if (a_key_event !== e_ke) begin n_fail++; $display("FAIL async_key_event step %0d got %0b want %0b", i, a_key_event, e_ke); end
            n_checks++; if (a_key_code !== e_kc) begin n_fail++; $display("FAIL async_key_code step %0d got %0d want %0d", i, a_key_code, e_kc); end
            if (i == 0) begin
                // Clear lands between edges; effects must be visible before any edge.
                #3 clear = 1'b1;
                keypad = '0;
                #1;
            end else if (i == 1) begin
                #1 clear = 1'b0;
                tick();
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_over_limit;
        do_clear();
        enable = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        keypad = 10'b01_0000_0000;
        for (int i = 1; i <= 5; i++) begin
            exp_ke_q.push_back(i == 3);
            exp_kc_q.push_back((i >= 3) ? 4'd8 : 4'd0);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            e_ke = exp_ke_q.pop_front(); e_kc = exp_kc_q.pop_front();
            n_checks++; if (l_count !== 3'd2) begin n_fail++; $display("FAIL over_count got %0d want 2", l_count); end
            n_checks++; if (l_match !== 1'b1) begin n_fail++; $display("FAIL over_match got %0b want 1", l_match); end
            n_checks++; if (l_key_event !== e_ke) begin n_fail++; $display("FAIL over_key_event got %0b want %0b", l_key_event, e_ke); end
            n_checks++; if (l_key_code !== e_kc) begin n_fail++; $display("FAIL over_key_code got %0d want %0d", l_key_code, e_kc); end
        end
        keypad = '0;
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) exp_cnt_q.push_back((2 + i > 5) ? 3'd5 : 3'(2 + i));
        while (exp_cnt_q.size() > 0) begin
            tick();
            e_cnt = exp_cnt_q.pop_front();
            n_checks++; if (l_count !== e_cnt) begin n_fail++; $display("FAIL lim5_count got %0d want %0d", l_count, e_cnt); end
            n_checks++; if (l_at_limit !== (e_cnt == 3'd5)) begin n_fail++; $display("FAIL lim5_at_limit got %0b at count %0d", l_at_limit, e_cnt); end
            n_checks++; if (l_wrapped !== 1'b0) begin n_fail++; $display("FAIL lim5_wrapped got %0b want 0", l_wrapped); end
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_wrap();
        test_key_load();
        test_key_priority();
        test_multi_key();
        test_clear_async();
        test_over_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
